key_value_entry: RTL and testbench

KEY_VALUE_ENTRY -- requirements
Module: key_value_entry

---
 rtl/key_value_entry.sv | 132 +++++++++++++
 tb/tb_key_value_entry.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/key_value_entry.sv
// key_value_entry: debounced three-key hex entry pad. The user composes a
// 16-bit value one nibble at a time and submits it to a consumer over a
// valid/ready handshake.
//
// Handshake: value_valid high means value_out holds an untransferred value
// and value_out stays constant until the transfer. A transfer happens on
// every rising edge where value_valid and value_ready are both high. A
// consumer may hold value_ready high permanently.
module key_value_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  key_n,
  input  logic [3:0]  sw,
  output logic [15:0] entry_value,
  output logic [2:0]  nibble_count,
  output logic        overflow,
  output logic [15:0] value_out,
  output logic        value_valid,
  input  logic        value_ready
);

  // Last count value: stable level flips on the DEBOUNCE_CYCLES-th differing cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  logic [2:0]       key_s1, key_s2;
  logic [3:0]       sw_s1, sw_s2;
  logic [CNT_W-1:0] db_cnt [3];
  logic [2:0]       key_stable;
  logic [2:0]       press;
  logic             clr_ev, sub_ev, shf_ev;
  logic             accept;
  state_t           state, state_next;

  // Two-flop synchronizers for the raw keys and switches; idle level is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '1;
      sw_s2  <= '1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Per-key debouncer; press pulses one cycle when the stable level falls to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_stable <= '1;
      press      <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (key_s2[i] != key_stable[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            key_stable[i] <= key_s2[i];
            db_cnt[i]     <= '0;
            press[i]      <= ~key_s2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Only the highest-priority event acts: clear > submit > shift.
  assign clr_ev = press[1];
  assign sub_ev = press[2] & ~press[1];
  assign shf_ev = press[0] & ~press[1] & ~press[2];

  // Handshake FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Handshake FSM next state; a submit is accepted only when idle and non-empty.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (sub_ev && (nibble_count != 3'd0)) begin
          accept     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (value_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign value_valid = (state == HOLD);

  // Entry register and submitted value; submit in HOLD leaves everything alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_value  <= '0;
      nibble_count <= '0;
      overflow     <= 1'b0;
      value_out    <= '0;
    end else if (clr_ev) begin
      entry_value  <= '0;
      nibble_count <= '0;
      overflow     <= 1'b0;
    end else if (accept) begin
      value_out    <= entry_value;
      entry_value  <= '0;
      nibble_count <= '0;
      overflow     <= 1'b0;
    end else if (shf_ev) begin
      entry_value <= {entry_value[11:0], sw_s2};
      if (nibble_count == 3'd4) overflow <= 1'b1;
      else                      nibble_count <= nibble_count + 3'd1;
    end
  end

endmodule

// File: tb/tb_key_value_entry.sv
// Testbench for key_value_entry with a short debounce interval.
module tb_key_value_entry;

  localparam int DB = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  key_n;
  logic [3:0]  sw;
  logic [15:0] entry_value;
  logic [2:0]  nibble_count;
  logic        overflow;
  logic [15:0] value_out;
  logic        value_valid;
  logic        value_ready;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int xfer_base;

  key_value_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw),
    .entry_value(entry_value), .nibble_count(nibble_count),
    .overflow(overflow), .value_out(value_out),
    .value_valid(value_valid), .value_ready(value_ready)
  );

  // Clock and transfer counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && value_valid && value_ready) xfer_cnt <= xfer_cnt + 1;
  end

  typedef struct {
    string       name;
    logic [2:0]  keys;    // bit set = key pressed
    logic [3:0]  nib;
    logic [15:0] e_entry;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic        e_valid;
    logic [15:0] e_out;
  } vec_t;

  vec_t vecs[$];

  task automatic add(string n, logic [2:0] k, logic [3:0] nb, logic [15:0] e,
                     logic [2:0] c, logic o, logic v, logic [15:0] vo);
    vec_t t;
    t.name = n; t.keys = k; t.nib = nb; t.e_entry = e; t.e_cnt = c;
    t.e_ovf = o; t.e_valid = v; t.e_out = vo;
    vecs.push_back(t);
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(string n, logic [15:0] e, logic [2:0] c, logic o,
                           logic v, logic [15:0] vo);
    check({n, ".entry_value"}, entry_value, e);
    check({n, ".nibble_count"}, 16'(nibble_count), 16'(c));
    check({n, ".overflow"}, 16'(overflow), 16'(o));
    check({n, ".value_valid"}, 16'(value_valid), 16'(v));
    check({n, ".value_out"}, value_out, vo);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the keys in mask together for 10 cycles, then release for 10.
  task automatic press_mask(logic [2:0] mask, logic [3:0] nib);
    sw    = nib;
    key_n = ~mask;
    cycles(10);
    key_n = 3'b111;
    cycles(10);
  endtask

  initial begin
    reset = 1'b1; key_n = 3'b111; sw = 4'h0; value_ready = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    check_all("reset", 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);

    add("shift_a",  3'b001, 4'hA, 16'h000A, 3'd1, 1'b0, 1'b0, 16'h0000);
    add("shift_3",  3'b001, 4'h3, 16'h00A3, 3'd2, 1'b0, 1'b0, 16'h0000);
    add("clear1",   3'b010, 4'h0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);
    add("n1",       3'b001, 4'h1, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0000);
    add("n2",       3'b001, 4'h2, 16'h0012, 3'd2, 1'b0, 1'b0, 16'h0000);
    add("n3",       3'b001, 4'h3, 16'h0123, 3'd3, 1'b0, 1'b0, 16'h0000);
    add("n4",       3'b001, 4'h4, 16'h1234, 3'd4, 1'b0, 1'b0, 16'h0000);
    add("n5_ovf",   3'b001, 4'h5, 16'h2345, 3'd4, 1'b1, 1'b0, 16'h0000);
    add("clear2",   3'b010, 4'h0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);
    add("b",        3'b001, 4'hB, 16'h000B, 3'd1, 1'b0, 1'b0, 16'h0000);
    add("e1",       3'b001, 4'hE, 16'h00BE, 3'd2, 1'b0, 1'b0, 16'h0000);
    add("e2",       3'b001, 4'hE, 16'h0BEE, 3'd3, 1'b0, 1'b0, 16'h0000);
    add("f",        3'b001, 4'hF, 16'hBEEF, 3'd4, 1'b0, 1'b0, 16'h0000);
    add("submit",   3'b100, 4'h0, 16'h0000, 3'd0, 1'b0, 1'b1, 16'hBEEF);
    add("hold_7",   3'b001, 4'h7, 16'h0007, 3'd1, 1'b0, 1'b1, 16'hBEEF);
    add("hold_sub", 3'b100, 4'h0, 16'h0007, 3'd1, 1'b0, 1'b1, 16'hBEEF);

    foreach (vecs[i]) begin
      press_mask(vecs[i].keys, vecs[i].nib);
      check_all(vecs[i].name, vecs[i].e_entry, vecs[i].e_cnt, vecs[i].e_ovf,
                vecs[i].e_valid, vecs[i].e_out);
    end
    check("no_xfer_while_not_ready", 16'(xfer_cnt), 16'd0);

    // Glitchy shift key: 3 low, 2 high, 3 low never reaches the interval.
    sw = 4'h9;
    key_n = 3'b110; cycles(3);
    key_n = 3'b111; cycles(2);
    key_n = 3'b110; cycles(3);
    key_n = 3'b111; cycles(10);
    check("glitch.entry_value", entry_value, 16'h0007);
    check("glitch.nibble_count", 16'(nibble_count), 16'd1);

    // One-cycle value_ready pulse completes the pending transfer.
    xfer_base = xfer_cnt;
    value_ready = 1'b1; cycles(1);
    value_ready = 1'b0;
    check("ready_pulse.value_valid", 16'(value_valid), 16'd0);
    check("ready_pulse.xfers", 16'(xfer_cnt - xfer_base), 16'd1);
    cycles(3);
    check("ready_pulse.value_out", value_out, 16'hBEEF);

    // value_ready held high: exactly one transfer for one submit.
    value_ready = 1'b1;
    cycles(5);
    xfer_base = xfer_cnt;
    press_mask(3'b100, 4'h0);
    check("ready_held.xfers", 16'(xfer_cnt - xfer_base), 16'd1);
    check_all("ready_held", 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0007);
    value_ready = 1'b0;

    // Submit with an empty entry is ignored.
    press_mask(3'b100, 4'h0);
    check("empty_sub.value_valid", 16'(value_valid), 16'd0);

    // Submit and clear together: clear wins, nothing transferred.
    press_mask(3'b001, 4'h9);
    check("pre_both.entry_value", entry_value, 16'h0009);
    press_mask(3'b110, 4'h0);
    check_all("sub_clr", 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0007);

    // Reset while holding 16'h1234 drops it.
    press_mask(3'b001, 4'h1);
    press_mask(3'b001, 4'h2);
    press_mask(3'b001, 4'h3);
    press_mask(3'b001, 4'h4);
    press_mask(3'b100, 4'h0);
    check_all("hold_1234", 16'h0000, 3'd0, 1'b0, 1'b1, 16'h1234);
    press_mask(3'b001, 4'h6);
    xfer_base = xfer_cnt;
    reset = 1'b1; cycles(1);
    check_all("reset_hold", 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);

    // Shift key held through reset release yields exactly one shift.
    sw = 4'h5; key_n = 3'b110;
    cycles(2);
    reset = 1'b0;
    cycles(12);
    key_n = 3'b111;
    cycles(10);
    check("held_reset.entry_value", entry_value, 16'h0005);
    check("held_reset.nibble_count", 16'(nibble_count), 16'd1);
    check("reset_hold.xfers", 16'(xfer_cnt - xfer_base), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
